// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: default widths,
// ownership states and port identifiers.
package data_memory_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 7;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } own_state_e;

    typedef enum logic [1:0] {
        PID_NONE = 2'd0,
        PID_A    = 2'd1,
        PID_B    = 2'd2
    } port_id_e;

    // The round-robin pointer always names the port that lost the last grant.
    function automatic port_id_e other_port(input port_id_e p);
        return (p == PID_A) ? PID_B : PID_A;
    endfunction

endpackage

// File: rtl/data_memory_arbiter_rr_pick2.sv
// Two-way round-robin pick: one-hot grant {B, A}; the pointer breaks ties.
module rr_pick2
    import data_memory_arbiter_pkg::*;
(
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  port_id_e   ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_a_i && req_b_i) begin
            gnt_o = (ptr_i == PID_B) ? 2'b10 : 2'b01;
        end else if (req_a_i) begin
            gnt_o = 2'b01;
        end else if (req_b_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter onto a single registered-read data memory, with
// round-robin fairness, lock-based ownership and in-order read-response tagging.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WrA,
    input  logic              WrB,
    input  logic              LockA,
    input  logic              LockB,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WDataA,
    input  logic [DATA_W-1:0] WDataB,
    output logic              GntA,
    output logic              GntB,
    output logic              RValidA,
    output logic              RValidB,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemReadData
);

    own_state_e        state_q, state_d;
    port_id_e          ptr_q, ptr_d;
    port_id_e          track_q, track_d;
    logic              gnt_a_q, gnt_b_q;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              cand_a, cand_b;
    logic [1:0]        pick;
    logic              win_a, win_b;

    // A port granted this cycle sits out the next pick; a locked owner shuts out the other port.
    always_comb begin
        cand_a = ReqA && !gnt_a_q;
        cand_b = ReqB && !gnt_b_q;
        if (state_q == ST_OWN_A && LockA) cand_b = 1'b0;
        if (state_q == ST_OWN_B && LockB) cand_a = 1'b0;
    end

    rr_pick2 u_rr_pick2 (
        .req_a_i (cand_a),
        .req_b_i (cand_b),
        .ptr_i   (ptr_q),
        .gnt_o   (pick)
    );

    assign win_a = pick[0];
    assign win_b = pick[1];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;

        // Dropping the lock releases ownership on the same edge the other port may win.
        if ((state_q == ST_OWN_A && !LockA) || (state_q == ST_OWN_B && !LockB)) begin
            state_d = ST_IDLE;
        end

        if (win_a) begin
            state_d     = LockA ? ST_OWN_A : ST_IDLE;
            ptr_d       = other_port(PID_A);
            mem_read_d  = !WrA;
            mem_write_d = WrA;
            addr_d      = AddrA;
            wdata_d     = WDataA;
        end else if (win_b) begin
            state_d     = LockB ? ST_OWN_B : ST_IDLE;
            ptr_d       = other_port(PID_B);
            mem_read_d  = !WrB;
            mem_write_d = WrB;
            addr_d      = AddrB;
            wdata_d     = WDataB;
        end
    end

    always_comb begin
        track_d = PID_NONE;
        if (mem_read_q) track_d = gnt_a_q ? PID_A : PID_B;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PID_A;
            track_q     <= PID_NONE;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            track_q     <= track_d;
            gnt_a_q     <= win_a;
            gnt_b_q     <= win_b;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign GntA         = gnt_a_q;
    assign GntB         = gnt_b_q;
    assign MemRead      = mem_read_q;
    assign MemWrite     = mem_write_q;
    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;
    assign RValidA      = (track_q == PID_A);
    assign RValidB      = (track_q == PID_B);
    assign RData        = MemReadData;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus a per-cycle reference model
// of the arbitration rules, with a registered-read memory behind the DUT.
module tb_data_memory_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          ReqA = 1'b0, ReqB = 1'b0, WrA = 1'b0, WrB = 1'b0;
    logic          LockA = 1'b0, LockB = 1'b0;
    logic [AW-1:0] AddrA = '0, AddrB = '0;
    logic [DW-1:0] WDataA = '0, WDataB = '0;
    logic          GntA, GntB, RValidA, RValidB, MemRead, MemWrite;
    logic [DW-1:0] RData, MemWriteData, MemReadData;
    logic [AW-1:0] MemAddress;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .ReqA(ReqA), .ReqB(ReqB), .WrA(WrA), .WrB(WrB),
        .LockA(LockA), .LockB(LockB),
        .AddrA(AddrA), .AddrB(AddrB), .WDataA(WDataA), .WDataB(WDataB),
        .GntA(GntA), .GntB(GntB), .RValidA(RValidA), .RValidB(RValidB),
        .RData(RData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
    );

    // Memory behind the arbiter: write and registered read on the same edge
    logic [DW-1:0] mem [128];
    always @(posedge Clk) if (MemWrite) mem[MemAddress] <= MemWriteData;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) MemReadData <= '0;
        else if (MemRead) MemReadData <= mem[MemAddress];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner 0=none 1=A 2=B, pointer 1=A 2=B
    logic          m_gA = 0, m_gB = 0, m_rd = 0, m_wr = 0, m_rvA = 0, m_rvB = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0, m_pend = '0;
    int            m_own = 0, m_ptr = 1;
    logic [DW-1:0] shadow [128];

    always @(posedge Clk or negedge Reset_n) begin : model
        int win, own;
        bit aA, aB, lk, wr;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        if (!Reset_n) begin
            m_gA <= 0; m_gB <= 0; m_rd <= 0; m_wr <= 0; m_rvA <= 0; m_rvB <= 0;
            m_addr <= '0; m_wdata <= '0; m_own <= 0; m_ptr <= 1;
        end else begin
            m_rvA <= m_rd && m_gA;
            m_rvB <= m_rd && m_gB;
            m_rdata <= m_pend;
            aA = ReqA && !m_gA;
            aB = ReqB && !m_gB;
            own = m_own;
            win = 0;
            if (own == 1 && LockA) win = aA ? 1 : 0;
            else if (own == 2 && LockB) win = aB ? 2 : 0;
            else begin
                own = 0;
                if (aA && aB) win = m_ptr;
                else if (aA) win = 1;
                else if (aB) win = 2;
            end
            m_gA <= (win == 1);
            m_gB <= (win == 2);
            m_rd <= 0;
            m_wr <= 0;
            if (win != 0) begin
                wr = (win == 1) ? WrA : WrB;
                ad = (win == 1) ? AddrA : AddrB;
                wd = (win == 1) ? WDataA : WDataB;
                lk = (win == 1) ? LockA : LockB;
                m_rd <= !wr;
                m_wr <= wr;
                m_addr <= ad;
                m_wdata <= wd;
                if (wr) shadow[ad] <= wd;
                else m_pend <= shadow[ad];
                m_ptr <= 3 - win;
                own = lk ? win : 0;
            end
            m_own <= own;
        end
    end

    always @(negedge Clk) begin
        chk("GntA", GntA, m_gA);
        chk("GntB", GntB, m_gB);
        chk("MemRead", MemRead, m_rd);
        chk("MemWrite", MemWrite, m_wr);
        chk("MemAddress", MemAddress, m_addr);
        chk("MemWriteData", MemWriteData, m_wdata);
        chk("RValidA", RValidA, m_rvA);
        chk("RValidB", RValidB, m_rvB);
        chk("RdWrExclusive", MemRead & MemWrite, 0);
        if (m_rvA || m_rvB) chk("RData", RData, m_rdata);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        ReqA = 0; ReqB = 0; WrA = 0; WrB = 0; LockA = 0; LockB = 0;
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    initial begin : stim
        logic [15:0] seq;
        int na;
        bit got_b;

        do_reset();
        chk("reset_GntA", GntA, 0);
        chk("reset_MemAddress", MemAddress, 0);
        chk("reset_RValidA", RValidA, 0);

        // Write then read of address 5 from port A
        ReqA = 1; WrA = 1; AddrA = 7'd5; WDataA = 32'hDEADBEEF;
        tick();
        chk("wr_GntA", GntA, 1);
        chk("wr_MemWrite", MemWrite, 1);
        chk("wr_MemAddress", MemAddress, 5);
        WrA = 0;
        tick();
        chk("masked_GntA", GntA, 0);
        tick();
        chk("rd_GntA", GntA, 1);
        chk("rd_MemRead", MemRead, 1);
        ReqA = 0;
        tick();
        chk("rd_RValidA", RValidA, 1);
        chk("rd_RData", RData, 32'hDEADBEEF);

        // Both ports requesting continuously alternate
        do_reset();
        ReqA = 1; WrA = 1; AddrA = 7'd40; WDataA = 32'h100;
        ReqB = 1; WrB = 1; AddrB = 7'd60; WDataB = 32'h200;
        seq = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seq = {seq[13:0], GntB, GntA};
            if (GntA) begin AddrA = AddrA + 1; WDataA = WDataA + 1; end
            if (GntB) begin AddrB = AddrB + 1; WDataB = WDataB + 1; end
        end
        chk("alternate_seq", seq, 16'h6666);
        ReqA = 0; ReqB = 0;
        tick();

        // Lock keeps B out for three A grants
        do_reset();
        ReqA = 1; WrA = 1; LockA = 1; AddrA = 7'd10; WDataA = 32'hA0;
        ReqB = 1; WrB = 1; AddrB = 7'd20; WDataB = 32'hB0;
        na = 0;
        got_b = 0;
        for (int i = 0; i < 20 && !got_b; i++) begin
            tick();
            if (GntB) begin
                got_b = 1;
                ReqB = 0;
            end
            if (GntA) begin
                na++;
                WDataA = WDataA + 1;
                if (na == 3) begin LockA = 0; ReqA = 0; end
            end
        end
        chk("lock_gotB", got_b, 1);
        chk("lock_A_grants_before_B", na, 3);
        tick();

        // Request withdrawn while locked out is never granted
        do_reset();
        ReqA = 1; WrA = 1; LockA = 1; AddrA = 7'd30; WDataA = 32'h30;
        ReqB = 1; WrB = 1; AddrB = 7'd31; WDataB = 32'h31;
        tick();
        chk("wd_GntA", GntA, 1);
        ReqA = 0;
        tick();
        chk("wd_blocked1", GntB, 0);
        tick();
        chk("wd_blocked2", GntB, 0);
        ReqB = 0; LockA = 0;
        tick();
        chk("wd_noGnt1", GntB, 0);
        tick();
        chk("wd_noGnt2", GntB, 0);

        // Reset during the read-data cycle discards the response
        ReqA = 1; WrA = 0; AddrA = 7'd5;
        tick();
        chk("rst_rd_GntA", GntA, 1);
        ReqA = 0;
        tick();
        chk("rst_rd_RValidA", RValidA, 1);
        #1 Reset_n = 0;
        #1;
        chk("rst_all_zero", {GntA, GntB, RValidA, RValidB, MemRead, MemWrite}, 0);
        chk("rst_MemAddress", MemAddress, 0);
        chk("rst_MemWriteData", MemWriteData, 0);
        chk("rst_RData", RData, 0);
        #1 Reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_RValid", {RValidA, RValidB}, 0);
        end

        // B writes the top address, A reads it back on the next cycle
        do_reset();
        ReqB = 1; WrB = 1; AddrB = 7'd127; WDataB = 32'hCAFEF00D;
        tick();
        chk("bnd_GntB", GntB, 1);
        ReqB = 0;
        ReqA = 1; WrA = 0; AddrA = 7'd127;
        tick();
        chk("bnd_GntA", GntA, 1);
        chk("bnd_MemAddress", MemAddress, 127);
        ReqA = 0;
        tick();
        chk("bnd_RValidA", RValidA, 1);
        chk("bnd_RData", RData, 32'hCAFEF00D);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
